branch_resolve_d: RTL

- Decode-stage branch resolution and hazard controller. It is the consumer side of the decode-stage register-equality comparator: it takes the comparator's EQ result and decides whether the operands fed to it can be trusted yet.
- It stalls fetch/decode until the branch operands are valid, then resolves BEQ/BNE and drives the PC redirect and IF/ID flush.
- It keeps saturating statistics counters and a sticky stall-watchdog error.

---
 rtl/branch_pkg.sv | 6 +
 rtl/sat_counter.sv | 14 +
 rtl/branch_resolve_d.sv | 77 +++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared state encoding and constants for decode-stage branch resolution
package branch_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int BR_SHIFT = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
    end
endmodule

// File: rtl/branch_resolve_d.sv
// branch_resolve_d: decode-stage BEQ/BNE resolution, operand-hazard stall, stats and stall watchdog
module branch_resolve_d
    import branch_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branchd,
    input  logic             bned,
    input  logic             eq,
    input  logic [4:0]       rsd,
    input  logic [4:0]       rtd,
    input  logic             regwritee,
    input  logic             memtorege,
    input  logic [4:0]       writerege,
    input  logic             regwritem,
    input  logic             memtoregm,
    input  logic [4:0]       writeregm,
    input  logic [31:0]      pcplus4d,
    input  logic [31:0]      signimmd,
    output logic             stallf,
    output logic             stalld,
    output logic             flushe,
    output logic             pcsrcd,
    output logic             flushd,
    output logic [31:0]      pcbranchd,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);
    localparam int RW = $clog2(MAX_STALL + 2);
    state_t state, state_nx;
    logic isbr, hz_e, hz_m, hz, taken;
    logic [RW-1:0] run;
    logic unused_ok;
    // execute-stage memtoreg and memory-stage regwrite play no part in branch operand readiness
    assign unused_ok = &{1'b0, memtorege, regwritem};
    assign isbr  = branchd ^ bned;
    assign hz_e  = regwritee && writerege != REG_ZERO && (writerege == rsd || writerege == rtd);
    assign hz_m  = memtoregm && writeregm != REG_ZERO && (writeregm == rsd || writeregm == rtd);
    assign hz    = isbr && (hz_e || hz_m);
    assign taken = isbr && !hz && (branchd ? eq : !eq);
    assign stallf = rst_n && hz;
    assign stalld = rst_n && hz;
    assign flushe = rst_n && hz;
    assign pcsrcd = rst_n && taken;
    assign flushd = rst_n && taken;
    assign pcbranchd = pcplus4d + (signimmd << BR_SHIFT);
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hz ? WAIT : IDLE;
            WAIT:    state_nx = hz ? WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // run length saturates one past the limit so the error cannot be missed on long stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run       <= '0;
            stall_err <= 1'b0;
        end else begin
            run       <= !hz ? '0 : (run == RW'(MAX_STALL + 1)) ? run : run + 1'b1;
            stall_err <= stall_err || (hz && run >= RW'(MAX_STALL));
        end
    end
    sat_counter #(.W(CNT_W)) u_br    (.clk(clk), .rst_n(rst_n), .inc(isbr && !hz), .q(br_cnt));
    sat_counter #(.W(CNT_W)) u_taken (.clk(clk), .rst_n(rst_n), .inc(taken),       .q(taken_cnt));
    sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc(hz),          .q(stall_cnt));
endmodule
